// File: rtl/ram_access_ctrl.sv
// Load/store access controller in front of a word-wide RAM: splits byte/half/word
// requests at any byte address into one or two aligned RAM beats and extends load data.
module ram_access_ctrl #(
    parameter int RAM_DEPTH         = 256,
    parameter int RAM_DEPTH_BIT_LEN = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic [31:0] ram_addr_o,
    output logic        ram_w_en_o,
    output logic [31:0] ram_w_data_o,
    output logic [3:0]  ram_w_sel_o,
    input  logic [31:0] ram_r_data_i
);

    localparam int ADDR_W = RAM_DEPTH_BIT_LEN + 2;

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1,
        RESP
    } state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] wdata_q, wdata_d;
    logic [63:0] acc_q, acc_d;

    logic        ready_q, ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic        ram_w_en_q, ram_w_en_d;
    logic [31:0] ram_w_data_q, ram_w_data_d;
    logic [3:0]  ram_w_sel_q, ram_w_sel_d;

    logic [32:0] req_end_addr;
    logic        req_oob;
    logic        req_err;
    logic [7:0]  req_mask;
    logic [63:0] req_lanes;
    logic [7:0]  cur_mask;
    logic [63:0] cur_lanes;
    logic [31:0] cur_base;

    function automatic logic [32:0] size_nbytes(input logic [1:0] size);
        case (size)
            2'd0:    return 33'd1;
            2'd1:    return 33'd2;
            default: return 33'd4;
        endcase
    endfunction

    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [7:0] base;
        case (size)
            2'd0:    base = 8'h01;
            2'd1:    base = 8'h03;
            default: base = 8'h0F;
        endcase
        return base << off;
    endfunction

    function automatic logic [63:0] lane_data(input logic [31:0] wdata, input logic [1:0] off);
        return {32'h0, wdata} << {off, 3'b000};
    endfunction

    function automatic logic [31:0] load_result(input logic [63:0] acc, input logic [1:0] off,
                                                input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = 32'(acc >> {off, 3'b000});
        case (size)
            2'd0:    return {{24{~uns & sh[7]}}, sh[7:0]};
            2'd1:    return {{16{~uns & sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    // The word-index compare only bites when RAM_DEPTH is not a power of two.
    always_comb begin
        req_end_addr = {1'b0, req_addr_i} + size_nbytes(req_size_i) - 33'd1;
        req_oob      = (req_end_addr[32:ADDR_W] != '0)
                    || ({1'b0, req_end_addr[ADDR_W-1:2]} >= (RAM_DEPTH_BIT_LEN+1)'(RAM_DEPTH));
        req_err      = (req_size_i == 2'd3) || req_oob;
        req_mask     = lane_mask(req_size_i, req_addr_i[1:0]);
        req_lanes    = lane_data(req_wdata_i, req_addr_i[1:0]);
        cur_mask     = lane_mask(size_q, addr_q[1:0]);
        cur_lanes    = lane_data(wdata_q, addr_q[1:0]);
        cur_base     = {addr_q[31:2], 2'b00};
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        addr_d       = addr_q;
        size_d       = size_q;
        uns_d        = uns_q;
        wdata_d      = wdata_q;
        acc_d        = acc_q;
        ready_d      = 1'b0;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        ram_addr_d   = '0;
        ram_w_en_d   = 1'b0;
        ram_w_data_d = '0;
        ram_w_sel_d  = '0;

        case (state_q)
            IDLE: begin
                if (req_valid_i && ready_q) begin
                    we_d    = req_we_i;
                    addr_d  = req_addr_i;
                    size_d  = req_size_i;
                    uns_d   = req_unsigned_i;
                    wdata_d = req_wdata_i;
                    acc_d   = '0;
                    if (req_err) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        // Outputs are registered, so the first beat is set up here.
                        state_d    = BEAT0;
                        ram_addr_d = {req_addr_i[31:2], 2'b00};
                        if (req_we_i) begin
                            ram_w_en_d   = 1'b1;
                            ram_w_sel_d  = req_mask[3:0];
                            ram_w_data_d = req_lanes[31:0];
                        end
                    end
                end else begin
                    ready_d = 1'b1;
                end
            end

            BEAT0: begin
                if (!we_q) begin
                    acc_d[31:0] = ram_r_data_i;
                end
                if (cur_mask[7:4] != 4'h0) begin
                    state_d    = BEAT1;
                    ram_addr_d = cur_base + 32'd4;
                    if (we_q) begin
                        ram_w_en_d   = 1'b1;
                        ram_w_sel_d  = cur_mask[7:4];
                        ram_w_data_d = cur_lanes[63:32];
                    end
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = we_q ? '0 : load_result(acc_d, addr_q[1:0], size_q, uns_q);
                end
            end

            BEAT1: begin
                if (!we_q) begin
                    acc_d[63:32] = ram_r_data_i;
                end
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = we_q ? '0 : load_result(acc_d, addr_q[1:0], size_q, uns_q);
            end

            RESP: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end

            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            addr_q       <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            wdata_q      <= '0;
            acc_q        <= '0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            ram_addr_q   <= '0;
            ram_w_en_q   <= 1'b0;
            ram_w_data_q <= '0;
            ram_w_sel_q  <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            wdata_q      <= wdata_d;
            acc_q        <= acc_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            ram_addr_q   <= ram_addr_d;
            ram_w_en_q   <= ram_w_en_d;
            ram_w_data_q <= ram_w_data_d;
            ram_w_sel_q  <= ram_w_sel_d;
        end
    end

    assign req_ready_o  = ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;
    assign ram_addr_o   = ram_addr_q;
    // Reset in the middle of a beat must keep that beat from landing in the RAM.
    assign ram_w_en_o   = ram_w_en_q & ~rst;
    assign ram_w_data_o = ram_w_data_q;
    assign ram_w_sel_o  = ram_w_sel_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: directed scenarios then random requests checked
// against a byte-array memory model and latency rules.
module tb_ram_access_ctrl;

    localparam int DEPTH     = 256;
    localparam int DBL       = 8;
    localparam int RAM_BYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic        req_uns = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] ram_addr;
    logic        ram_w_en;
    logic [31:0] ram_w_data;
    logic [3:0]  ram_w_sel;
    logic [31:0] ram_r_data;

    always #5 clk = ~clk;

    ram_access_ctrl #(.RAM_DEPTH(DEPTH), .RAM_DEPTH_BIT_LEN(DBL)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_size_i(req_size), .req_unsigned_i(req_uns),
        .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
        .ram_addr_o(ram_addr), .ram_w_en_o(ram_w_en), .ram_w_data_o(ram_w_data),
        .ram_w_sel_o(ram_w_sel), .ram_r_data_i(ram_r_data)
    );

    // Downstream RAM: combinational read, byte-lane write on the clock edge.
    logic [31:0] mem [DEPTH] = '{default: '0};
    assign ram_r_data = mem[ram_addr[DBL+1:2]];
    always @(posedge clk) begin
        if (ram_w_en) begin
            for (int l = 0; l < 4; l++) begin
                if (ram_w_sel[l]) mem[ram_addr[DBL+1:2]][8*l +: 8] <= ram_w_data[8*l +: 8];
            end
        end
    end

    // Reference memory, one entry per byte address.
    logic [7:0] gold [RAM_BYTES] = '{default: '0};

    int n_pass = 0;
    int n_total = 0;
    int txn_id = 0;

    int          lat;
    logic        cyc_we   [6];
    logic [31:0] cyc_addr [6];
    logic [31:0] cyc_data [6];
    logic [3:0]  cyc_sel  [6];
    logic [31:0] r_rdata;
    logic        r_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s (txn %0d): observed 0x%08h expected 0x%08h", tag, txn_id, obs, exp);
    endtask

    function automatic logic [31:0] gold_word(input int w);
        return {gold[4*w+3], gold[4*w+2], gold[4*w+1], gold[4*w]};
    endfunction

    task automatic txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata);
        int              nb;
        int              off;
        longint unsigned end_addr;
        bit              err;
        bit              split;
        int              exp_lat;
        int              exp_writes;
        int              writes;
        logic [31:0]     exp_rd;
        logic [31:0]     base;
        txn_id++;
        nb       = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        off      = int'(addr % 4);
        end_addr = longint'(addr) + longint'(nb) - 1;
        err      = (size == 2'd3) || (end_addr >= longint'(RAM_BYTES));
        split    = (off + nb) > 4;
        exp_lat  = err ? 1 : (split ? 3 : 2);
        exp_writes = (we && !err) ? (split ? 2 : 1) : 0;
        base     = addr & 32'hFFFF_FFFC;
        exp_rd   = '0;
        if (!err && !we) begin
            for (int i = 0; i < nb; i++) exp_rd |= 32'(gold[int'(addr) + i]) << (8 * i);
            if (!uns && nb < 4 && exp_rd[8*nb-1]) exp_rd |= 32'hFFFF_FFFF << (8 * nb);
        end

        chk("ready_idle", 32'(req_ready), 32'd1);
        req_we = we; req_addr = addr; req_size = size; req_uns = uns; req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;

        lat = 0;
        for (int c = 1; c <= 5; c++) begin
            cyc_we[c] = ram_w_en; cyc_addr[c] = ram_addr;
            cyc_data[c] = ram_w_data; cyc_sel[c] = ram_w_sel;
            if (resp_valid) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        r_rdata = resp_rdata;
        r_err   = resp_err;

        chk("latency", 32'(lat), 32'(exp_lat));
        chk("resp_err", 32'(r_err), 32'(err));
        chk("resp_rdata", r_rdata, exp_rd);
        chk("resp_ram_w_en", 32'(ram_w_en), 32'd0);
        chk("resp_ram_addr", ram_addr, 32'd0);
        writes = 0;
        for (int c = 1; c < lat; c++) if (cyc_we[c]) writes++;
        chk("write_beats", 32'(writes), 32'(exp_writes));
        if (!err && lat > 1) chk("beat0_addr", cyc_addr[1], base);
        if (!err && split && lat > 2) chk("beat1_addr", cyc_addr[2], base + 32'd4);

        @(posedge clk); #1;
        chk("resp_pulse_end", 32'(resp_valid), 32'd0);
        chk("ready_after", 32'(req_ready), 32'd1);

        if (we && !err) begin
            for (int i = 0; i < nb; i++) gold[int'(addr) + i] = wdata[8*i +: 8];
            chk("ram_word0", mem[int'(addr) / 4], gold_word(int'(addr) / 4));
            if (split) chk("ram_word1", mem[int'(addr) / 4 + 1], gold_word(int'(addr) / 4 + 1));
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        int          r;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_ram_w_en", 32'(ram_w_en), 32'd0);
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_ram_w_sel", 32'(ram_w_sel), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_rdata", resp_rdata, 32'd0);

        // Aligned word store and load.
        txn(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF);
        chk("w_sel_word", 32'(cyc_sel[1]), 32'hF);
        chk("w_data_word", cyc_data[1], 32'hDEADBEEF);
        chk("w_addr_word", cyc_addr[1], 32'h10);
        txn(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
        chk("ld_word", r_rdata, 32'hDEADBEEF);

        // Byte lanes and extension.
        txn(1'b1, 32'h21, 2'd0, 1'b0, 32'h80);
        chk("w_sel_byte", 32'(cyc_sel[1]), 32'h2);
        chk("w_data_byte", cyc_data[1], 32'h00008000);
        txn(1'b0, 32'h21, 2'd0, 1'b0, 32'h0);
        chk("ld_byte_signed", r_rdata, 32'hFFFFFF80);
        txn(1'b0, 32'h21, 2'd0, 1'b1, 32'h0);
        chk("ld_byte_unsigned", r_rdata, 32'h00000080);

        // Split word store over zeroed RAM.
        txn(1'b1, 32'h3E, 2'd2, 1'b0, 32'h11223344);
        chk("split_b0_addr", cyc_addr[1], 32'h3C);
        chk("split_b0_sel", 32'(cyc_sel[1]), 32'hC);
        chk("split_b0_data", cyc_data[1], 32'h33440000);
        chk("split_b1_addr", cyc_addr[2], 32'h40);
        chk("split_b1_sel", 32'(cyc_sel[2]), 32'h3);
        chk("split_b1_data", cyc_data[2], 32'h00001122);
        txn(1'b0, 32'h3E, 2'd2, 1'b0, 32'h0);
        chk("ld_split_word", r_rdata, 32'h11223344);
        txn(1'b0, 32'h3C, 2'd2, 1'b0, 32'h0);
        chk("ld_word_3c", r_rdata, 32'h33440000);

        // Split signed halfword load.
        txn(1'b1, 32'h04, 2'd2, 1'b0, 32'hAB000000);
        txn(1'b1, 32'h08, 2'd2, 1'b0, 32'h000000CD);
        txn(1'b0, 32'h07, 2'd1, 1'b0, 32'h0);
        chk("ld_split_half", r_rdata, 32'hFFFFCDAB);

        // Errors.
        txn(1'b1, 32'h0, 2'd3, 1'b0, 32'h12345678);
        chk("err_size3", 32'(r_err), 32'd1);
        txn(1'b1, 32'h3FE, 2'd2, 1'b0, 32'h12345678);
        chk("err_span_top", 32'(r_err), 32'd1);
        txn(1'b0, 32'hFFFF_FFFF, 2'd2, 1'b0, 32'h0);
        chk("err_wrap", 32'(r_err), 32'd1);

        // Reset while the second beat of a split store is on the bus.
        txn_id++;
        req_we = 1'b1; req_addr = 32'h82; req_size = 2'd2; req_uns = 1'b0;
        req_wdata = 32'h11223344; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rstmid_b0_sel", 32'(ram_w_sel), 32'hC);
        @(posedge clk); #1;
        chk("rstmid_b1_sel", 32'(ram_w_sel), 32'h3);
        rst = 1'b1;
        #1;
        chk("rstmid_w_en_gated", 32'(ram_w_en), 32'd0);
        @(posedge clk); #1;
        chk("rstmid_ram_addr", ram_addr, 32'd0);
        chk("rstmid_w_sel", 32'(ram_w_sel), 32'd0);
        chk("rstmid_w_data", ram_w_data, 32'd0);
        chk("rstmid_resp_valid", 32'(resp_valid), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_ready", 32'(req_ready), 32'd1);
        chk("rstmid_no_resp", 32'(resp_valid), 32'd0);
        gold[32'h82] = 8'h44;
        gold[32'h83] = 8'h33;
        chk("rstmid_word80", mem[32'h80 / 4], 32'h33440000);
        chk("rstmid_word84", mem[32'h84 / 4], 32'h00000000);

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 19));
            if (r < 16)      a = 32'($urandom_range(0, RAM_BYTES - 1));
            else if (r < 18) a = 32'($urandom_range(RAM_BYTES - 6, RAM_BYTES + 3));
            else             a = $urandom;
            r = int'($urandom_range(0, 15));
            sz = (r < 5) ? 2'd0 : (r < 10) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
            txn(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
- Load/store access controller directly upstream of the word-wide RAM.
- Accepts byte, halfword and word requests at any byte address from the core over a valid/ready handshake.
- Turns each request into one or two aligned RAM word accesses with byte-lane write selects, and returns sign- or zero-extended load data.
- Rejects requests with an illegal size or an out-of-range address.

Parameters:
- RAM_DEPTH, 256, number of 32-bit words in the downstream RAM.
- RAM_DEPTH_BIT_LEN, 8, log2(RAM_DEPTH); the RAM word index is addr[RAM_DEPTH_BIT_LEN+1:2].

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active high.
- req_valid_i  input  1  core request valid.
- req_ready_o  output  1  controller can accept a request.
- req_we_i  input  1  1 = store, 0 = load.
- req_addr_i  input  32  byte address.
- req_size_i  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned_i  input  1  zero-extend load data (1) or sign-extend it (0).
- req_wdata_i  input  32  store data, right-aligned.
- resp_valid_o  output  1  one-cycle response pulse.
- resp_rdata_o  output  32  load result; 0 for stores and errors.
- resp_err_o  output  1  request rejected; qualified by resp_valid_o.
- ram_addr_o  output  32  word-aligned RAM address (bits [1:0] = 0).
- ram_w_en_o  output  1  RAM write enable.
- ram_w_data_o  output  32  RAM write data, lane-aligned.
- ram_w_sel_o  output  4  RAM byte-lane write select.
- ram_r_data_i  input  32  RAM read data; combinational from ram_addr_o, same cycle.

Behaviour:
- Reset (synchronous, rst = 1):
  - Controller goes to IDLE.
  - req_ready_o = 1 after reset releases; resp_valid_o = 0, resp_err_o = 0, resp_rdata_o = 0.
  - ram_addr_o = 0, ram_w_en_o = 0, ram_w_data_o = 0, ram_w_sel_o = 0.
  - All captured request and load-accumulator registers cleared.
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE:
  - req_ready_o = 1 only in this state.
  - On req_valid_i & req_ready_o, the controller captures we, addr, size, unsigned and wdata.
  - Derived values: off = addr[1:0]; nbytes = 1/2/4 by size; mask8 = ((1 << nbytes) - 1) << off.
- Error check at accept time:
  - A request is an error if size = 3, or if the 33-bit end address addr + nbytes - 1 has any bit at or above bit RAM_DEPTH_BIT_LEN+2 set.
  - Error requests go straight to RESP with resp_err_o = 1, make no RAM access and never assert ram_w_en_o.
  - Otherwise the controller goes to BEAT0.
- BEAT0:
  - ram_addr_o = {addr[31:2], 2'b00}.
  - For stores: ram_w_sel_o = mask8[3:0], ram_w_data_o = (wdata << 8*off)[31:0], ram_w_en_o = 1.
  - For loads: ram_w_en_o = 0, ram_w_sel_o = 0, and ram_r_data_i is latched into acc[31:0].
  - If mask8[7:4] != 0 (split access), next state is BEAT1; else RESP.
- BEAT1:
  - ram_addr_o = {addr[31:2], 2'b00} + 4.
  - For stores: ram_w_sel_o = mask8[7:4], ram_w_data_o = (wdata << 8*off)[63:32], ram_w_en_o = 1.
  - For loads: ram_r_data_i is latched into acc[63:32].
  - Next state is RESP.
- RESP:
  - resp_valid_o = 1 for exactly one cycle, then IDLE.
  - Load result = (acc >> 8*off) truncated to nbytes, then sign-extended (unsigned = 0) or zero-extended (unsigned = 1) to 32 bits.
  - Stores and errors return resp_rdata_o = 0.
- Latency, with acceptance edge at cycle N:
  - aligned or non-spanning access: resp_valid_o at N+2;
  - split access: resp_valid_o at N+3;
  - error: resp_valid_o at N+1.
- Throughput: next acceptance is possible in the cycle after RESP. There is no back-pressure on the response; the core must take it.
- Outside BEAT0/BEAT1: ram_w_en_o = 0, ram_w_sel_o = 0, ram_w_data_o = 0, ram_addr_o = 0.
- resp_valid_o, resp_rdata_o and resp_err_o are zero outside RESP.
- Reset mid-operation: any pending beat is dropped. A BEAT0 store already committed stays in RAM, and the BEAT1 half is not written. No response is issued.
- req_valid_i while not IDLE is ignored; the core holds the request until it sees ready.
- Wrap-around: an end address that overflows 32 bits is caught as an error by the 33-bit compare.

Test Plan:
- Aligned word store then load: store addr 0x10, data 0xDEADBEEF, size 2 -> one write, w_sel 4'b1111, ram_addr 0x10, resp at N+2. Then load 0x10 -> resp_rdata 0xDEADBEEF.
- Byte lanes and extension: store byte 0x80 at 0x21 -> w_sel 4'b0010, w_data 0x00008000. Load byte signed at 0x21 -> 0xFFFFFF80; unsigned -> 0x00000080.
- Split word store, over a zero-initialised RAM: store 0x11223344 at 0x3E -> beat0 addr 0x3C, w_sel 4'b1100, w_data 0x33440000; beat1 addr 0x40, w_sel 4'b0011, w_data 0x00001122; resp at N+3. Load word 0x3E -> 0x11223344; word 0x3C -> 0x33440000.
- Split signed halfword load at 0x07 with RAM word 0x04 = 0xAB000000 and word 0x08 = 0x000000CD -> resp_rdata 0xFFFFCDAB.
- Errors, each giving resp_err_o = 1 at N+1 with no ram_w_en_o pulse:
  - size 3;
  - word at 0x3FE, which spans the RAM_DEPTH = 256 limit;
  - address 0xFFFFFFFF.
- Reset during split store: assert rst in BEAT1 -> outputs zero next cycle, no resp_valid_o, only beat0 bytes written, req_ready_o = 1 after release.
